// File: rtl/strobe_sequencer_if.sv
// rtl/strobe_sequencer_if.sv - configuration, run-control and counter-status bundle for strobe_sequencer
interface strobe_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             strobe_out;
  logic             ctr_rst;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_reset_value;
  logic             ctr_strobe;
  logic             ctr_ready;
  logic             ctr_valid;

  modport slave (
    input  cfg_valid, cfg_period, cfg_count, start, stop,
    input  ctr_strobe, ctr_ready, ctr_valid,
    output cfg_ready, busy, done, cfg_err, strobe_out,
    output ctr_rst, ctr_enable, ctr_reset_value
  );

  modport master (
    output cfg_valid, cfg_period, cfg_count, start, stop,
    output ctr_strobe, ctr_ready, ctr_valid,
    input  cfg_ready, busy, done, cfg_err, strobe_out,
    input  ctr_rst, ctr_enable, ctr_reset_value
  );
endinterface

// File: rtl/strobe_sequencer.sv
// rtl/strobe_sequencer.sv - start/stop sequencer pacing an attached strobe counter one tick at a time
// Optional STROBE_SEQ_PENDING_EN: one-deep pending period that may be offered while a run is active.
module strobe_sequencer #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  strobe_sequencer_if.slave seq_io
);
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             loaded_q, loaded_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] strobe_cnt_q, strobe_cnt_d;
  logic             en_q;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cfg_ready_c;
  logic             accept;
  logic             period_ok;
  logic             strobe_c;
  logic             hit;
  logic             go;
  logic             en_c;
  logic             ctr_rst_c;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_latency;

`ifdef STROBE_SEQ_PENDING_EN
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
`endif

  // The counter's latency is absorbed by the ready handshake, so it is not needed here.
  assign unused_latency = (LATENCY > 0);

`ifdef STROBE_SEQ_PENDING_EN
  assign cfg_ready_c = !rst && ((state_q == S_IDLE) || !pend_valid_q);
`else
  assign cfg_ready_c = !rst && (state_q == S_IDLE);
`endif

  assign accept    = seq_io.cfg_valid && cfg_ready_c;
  assign period_ok = (seq_io.cfg_period >= WIDTH'(2));
  assign strobe_c  = seq_io.ctr_strobe && seq_io.ctr_valid;
  assign cnt_inc   = strobe_cnt_q + CNT_W'(1);
  assign hit       = strobe_c && (count_q != '0) && (cnt_inc == count_q);
  assign go        = !rst && (state_q == S_IDLE) && seq_io.start && loaded_q;

  always_comb begin
    state_d      = state_q;
    en_c         = 1'b0;
    ctr_rst_c    = 1'b0;
    done_d       = 1'b0;
    err_d        = accept && !period_ok;
    count_d      = accept ? seq_io.cfg_count : count_q;
    loaded_d     = loaded_q || (accept && period_ok);
    strobe_cnt_d = strobe_c ? cnt_inc : strobe_cnt_q;
    period_d     = period_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d      = S_ARM;
          ctr_rst_c    = 1'b1;
          strobe_cnt_d = '0;
        end
      end
      S_ARM: begin
        if (seq_io.stop) begin
          state_d = S_DRAIN;
        end else if (seq_io.ctr_ready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A tick is never issued in the cycle the run is ending.
        if (seq_io.stop || hit) begin
          state_d = S_DRAIN;
        end else if (!rst && seq_io.ctr_ready && !en_q) begin
          en_c = 1'b1;
        end
      end
      S_DRAIN: begin
        if (seq_io.ctr_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef STROBE_SEQ_PENDING_EN
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (state_q == S_IDLE) begin
      if (pend_valid_q) begin
        period_d     = pend_q;
        pend_valid_d = 1'b0;
      end
      if (accept && period_ok) begin
        period_d = seq_io.cfg_period;
      end
    end else begin
      // Swap the period only where the counter has just reloaded and no tick is in flight.
      if (pend_valid_q && seq_io.ctr_strobe && !en_c) begin
        period_d     = pend_q;
        pend_valid_d = 1'b0;
      end
      if (accept && period_ok) begin
        pend_d       = seq_io.cfg_period;
        pend_valid_d = 1'b1;
      end
    end
`else
    if (accept && period_ok) begin
      period_d = seq_io.cfg_period;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      period_q     <= WIDTH'(2);
      loaded_q     <= 1'b0;
      count_q      <= '0;
      strobe_cnt_q <= '0;
      en_q         <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef STROBE_SEQ_PENDING_EN
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      loaded_q     <= loaded_d;
      count_q      <= count_d;
      strobe_cnt_q <= strobe_cnt_d;
      en_q         <= en_c;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef STROBE_SEQ_PENDING_EN
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
`endif
    end
  end

  assign seq_io.cfg_ready       = cfg_ready_c;
  assign seq_io.busy            = (state_q != S_IDLE);
  assign seq_io.done            = done_q;
  assign seq_io.cfg_err         = err_q;
  assign seq_io.strobe_out      = strobe_c;
  assign seq_io.ctr_rst         = rst || ctr_rst_c;
  assign seq_io.ctr_enable      = en_c;
  assign seq_io.ctr_reset_value = period_q;
endmodule
